// File: rtl/pwm_peripheral.sv
// 16-channel PWM output stage: prescaled 255-tick period counter, duty shadowed per
// period, per-bit enable / PWM select, all outputs registered.
module pwm_peripheral #(
   parameter int unsigned DIV = 4
) (
   input  logic        SCLK,
   input  logic        rst_n,
   input  logic [7:0]  en_out_lo,
   input  logic [7:0]  en_out_hi,
   input  logic [7:0]  en_pwm_lo,
   input  logic [7:0]  en_pwm_hi,
   input  logic [7:0]  duty,
   output logic [15:0] out,
   output logic        period_start
);

   localparam logic [15:0] PRESC_MAX = 16'(DIV - 1);

   logic [15:0] presc_q, presc_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  shadow_q, shadow_d;
   logic [15:0] out_q, out_d;
   logic        wrap_q, wrap_d;
   logic        ps_q;
   logic        tick, pwm;
   logic [15:0] en_out, en_pwm;

   assign en_out = {en_out_hi, en_out_lo};
   assign en_pwm = {en_pwm_hi, en_pwm_lo};

   always_comb begin
      tick    = (presc_q >= PRESC_MAX);
      presc_d = tick ? '0 : presc_q + 16'd1;

      // 255 is unreachable in normal counting; it is folded back to 0 on any cycle
      cnt_d = cnt_q;
      if (cnt_q == 8'd255)
         cnt_d = '0;
      else if (tick)
         cnt_d = (cnt_q == 8'd254) ? '0 : cnt_q + 8'd1;

      wrap_d   = tick && (cnt_q == 8'd254);
      shadow_d = wrap_d ? duty : shadow_q;

      pwm   = (cnt_q < shadow_q);
      out_d = en_out & (~en_pwm | {16{pwm}});
   end

   // wrap_q marks the first cycle with the counter at 0; period_start follows it by
   // one cycle so it lines up with the first output cycle of the new period
   always_ff @(posedge SCLK or negedge rst_n) begin
      if (!rst_n) begin
         presc_q  <= '0;
         cnt_q    <= '0;
         shadow_q <= '0;
         out_q    <= '0;
         wrap_q   <= 1'b0;
         ps_q     <= 1'b0;
      end else begin
         presc_q  <= presc_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         out_q    <= out_d;
         wrap_q   <= wrap_d;
         ps_q     <= wrap_q;
      end
   end

   assign out          = out_q;
   assign period_start = ps_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral: DIV=1 and DIV=4 instances share stimulus;
// a tick-arithmetic reference model predicts out/period_start every cycle.
module tb_pwm_peripheral;

   logic        SCLK = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] en_out = '0;
   logic [15:0] en_pwm = '0;
   logic [7:0]  duty = '0;
   logic [15:0] out1, out4;
   logic        ps1, ps4;

   int n_checks = 0;
   int n_fail = 0;

   always #5 SCLK = ~SCLK;

   pwm_peripheral #(.DIV(1)) u1 (
      .SCLK(SCLK), .rst_n(rst_n),
      .en_out_lo(en_out[7:0]), .en_out_hi(en_out[15:8]),
      .en_pwm_lo(en_pwm[7:0]), .en_pwm_hi(en_pwm[15:8]),
      .duty(duty), .out(out1), .period_start(ps1)
   );

   pwm_peripheral #(.DIV(4)) u4 (
      .SCLK(SCLK), .rst_n(rst_n),
      .en_out_lo(en_out[7:0]), .en_out_hi(en_out[15:8]),
      .en_pwm_lo(en_pwm[7:0]), .en_pwm_hi(en_pwm[15:8]),
      .duty(duty), .out(out4), .period_start(ps4)
   );

   // Reference model: after k clock edges since reset the period counter is
   // floor(k/DIV) mod 255, and a new period begins whenever k is a multiple of 255*DIV.
   int unsigned k;
   int unsigned m_div, m_per, m_cnt;
   logic [7:0]  m_shadow [2];
   logic [15:0] m_out [2];
   logic        m_ps [2];

   always @(posedge SCLK or negedge rst_n) begin
      if (!rst_n) begin
         k = 0;
         for (int d = 0; d < 2; d++) begin
            m_shadow[d] = '0;
            m_out[d]    = '0;
            m_ps[d]     = 1'b0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            m_div = (d == 0) ? 1 : 4;
            m_per = 255 * m_div;
            m_cnt = (k / m_div) % 255;
            m_out[d] = en_out & (~en_pwm | ((m_cnt < int'(m_shadow[d])) ? 16'hFFFF : 16'h0000));
            m_ps[d]  = (k > 0) && (k % m_per == 0);
            if ((k + 1) % m_per == 0) m_shadow[d] = duty;
         end
         k = k + 1;
      end
   end

   task automatic test_reset;
      en_out = 16'hFFFF; en_pwm = 16'h0000; duty = 8'hFF;
      repeat (3) @(negedge SCLK);
      n_checks++; if (out1 !== 16'h0000) begin n_fail++; $display("FAIL reset_out1: got %h expected 0000", out1); end
      n_checks++; if (out4 !== 16'h0000) begin n_fail++; $display("FAIL reset_out4: got %h expected 0000", out4); end
      n_checks++; if (ps1 !== 1'b0) begin n_fail++; $display("FAIL reset_ps1: got %b expected 0", ps1); end
      n_checks++; if (ps4 !== 1'b0) begin n_fail++; $display("FAIL reset_ps4: got %b expected 0", ps4); end
      en_out = '0; duty = '0;
      rst_n = 1'b1;
      @(negedge SCLK);
   endtask

   task automatic test_static_enables;
      en_out = 16'hFFFF; en_pwm = 16'h0000;
      @(negedge SCLK);
      n_checks++; if (out1 !== 16'hFFFF) begin n_fail++; $display("FAIL static_all_on_div1: got %h expected FFFF", out1); end
      n_checks++; if (out4 !== 16'hFFFF) begin n_fail++; $display("FAIL static_all_on_div4: got %h expected FFFF", out4); end
      en_out[7:0] = 8'h00;
      @(negedge SCLK);
      n_checks++; if (out1 !== 16'hFF00) begin n_fail++; $display("FAIL static_lo_off: got %h expected FF00", out1); end
   endtask

   task automatic test_duty_half;
      int w, high, shape_err, ps_extra;
      en_out = 16'h0001; en_pwm = 16'h0001; duty = 8'h80;
      repeat (2) @(negedge SCLK);
      w = 0;
      while (ps1 !== 1'b1 && w < 300) begin @(negedge SCLK); w++; end
      n_checks++; if (ps1 !== 1'b1) begin n_fail++; $display("FAIL half_wait_ps: got %b expected 1 within 300 cycles", ps1); end
      high = 0; shape_err = 0; ps_extra = 0;
      for (int i = 0; i < 255; i++) begin
         if (i > 0) @(negedge SCLK);
         high += int'(out1[0]);
         if (out1[0] !== (i < 128)) shape_err++;
         if (i > 0 && ps1 === 1'b1) ps_extra++;
      end
      @(negedge SCLK);
      n_checks++; if (high != 128) begin n_fail++; $display("FAIL half_high_cycles: got %0d expected 128", high); end
      n_checks++; if (shape_err != 0) begin n_fail++; $display("FAIL half_shape: got %0d bad cycles expected 0", shape_err); end
      n_checks++; if (ps_extra != 0) begin n_fail++; $display("FAIL half_ps_extra: got %0d pulses expected 0", ps_extra); end
      n_checks++; if (ps1 !== 1'b1) begin n_fail++; $display("FAIL half_ps_spacing: got %b at +255 expected 1", ps1); end
   endtask

   task automatic test_extremes;
      logic [7:0] codes [2];
      int w, errs;
      codes[0] = 8'h00; codes[1] = 8'hFF;
      for (int c = 0; c < 2; c++) begin
         duty = codes[c];
         repeat (2) @(negedge SCLK);
         w = 0;
         while (ps1 !== 1'b1 && w < 300) begin @(negedge SCLK); w++; end
         n_checks++; if (ps1 !== 1'b1) begin n_fail++; $display("FAIL extreme_wait_ps: got %b expected 1 (duty %h)", ps1, codes[c]); end
         errs = 0;
         for (int i = 0; i < 765; i++) begin
            if (i > 0) @(negedge SCLK);
            if (out1[0] !== (codes[c] == 8'hFF)) errs++;
         end
         n_checks++; if (errs != 0) begin n_fail++; $display("FAIL extreme_constant: got %0d glitch cycles expected 0 (duty %h)", errs, codes[c]); end
      end
   endtask

   task automatic test_div4;
      int w, high1, high2, ps_err;
      duty = 8'h40; en_out = 16'h0001; en_pwm = 16'h0001;
      repeat (2) @(negedge SCLK);
      w = 0;
      while (ps4 !== 1'b1 && w < 1100) begin @(negedge SCLK); w++; end
      n_checks++; if (ps4 !== 1'b1) begin n_fail++; $display("FAIL div4_wait_ps: got %b expected 1 within 1100 cycles", ps4); end
      high1 = 0; high2 = 0; ps_err = 0;
      for (int i = 0; i <= 2040; i++) begin
         if (i > 0) @(negedge SCLK);
         if (i < 1020) high1 += int'(out4[0]);
         else if (i < 2040) high2 += int'(out4[0]);
         if (ps4 !== (i % 1020 == 0)) ps_err++;
         if (i == 500) duty = 8'hC0;
      end
      n_checks++; if (high1 != 256) begin n_fail++; $display("FAIL div4_high_0x40: got %0d expected 256", high1); end
      n_checks++; if (high2 != 768) begin n_fail++; $display("FAIL div4_high_0xC0: got %0d expected 768", high2); end
      n_checks++; if (ps_err != 0) begin n_fail++; $display("FAIL div4_ps_period: got %0d misplaced cycles expected 0", ps_err); end
   endtask

   task automatic test_reset_mid;
      int w, j, high;
      bit found;
      duty = 8'h80; en_out = 16'h0001; en_pwm = 16'h0001;
      repeat (2) @(negedge SCLK);
      w = 0;
      while (ps1 !== 1'b1 && w < 300) begin @(negedge SCLK); w++; end
      repeat (50) @(negedge SCLK);
      n_checks++; if (out1[0] !== 1'b1) begin n_fail++; $display("FAIL rstmid_high_phase: got %b expected 1", out1[0]); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (out1 !== 16'h0000) begin n_fail++; $display("FAIL rstmid_async_out1: got %h expected 0000", out1); end
      n_checks++; if (ps1 !== 1'b0 || ps4 !== 1'b0) begin n_fail++; $display("FAIL rstmid_async_ps: got %b%b expected 00", ps1, ps4); end
      n_checks++; if (out4 !== 16'h0000) begin n_fail++; $display("FAIL rstmid_async_out4: got %h expected 0000", out4); end
      @(negedge SCLK);
      rst_n = 1'b1;
      found = 1'b0; high = 0; j = 0;
      while (!found && j < 300) begin
         @(negedge SCLK); j++;
         if (ps1 === 1'b1) found = 1'b1;
         else high += int'(out1[0]);
      end
      n_checks++; if (!found || j != 256) begin n_fail++; $display("FAIL rstmid_first_ps: got cycle %0d expected 256", j); end
      n_checks++; if (high != 0) begin n_fail++; $display("FAIL rstmid_no_early_pwm: got %0d high cycles expected 0", high); end
      n_checks++; if (out1[0] !== 1'b1) begin n_fail++; $display("FAIL rstmid_pwm_after_wrap: got %b expected 1", out1[0]); end
   endtask

   task automatic test_random;
      for (int i = 0; i < 4000; i++) begin
         @(negedge SCLK);
         n_checks++; if (out1 !== m_out[0]) begin n_fail++; $display("FAIL rand_out_div1 @%0d: got %h expected %h", i, out1, m_out[0]); end
         n_checks++; if (ps1 !== m_ps[0]) begin n_fail++; $display("FAIL rand_ps_div1 @%0d: got %b expected %b", i, ps1, m_ps[0]); end
         n_checks++; if (out4 !== m_out[1]) begin n_fail++; $display("FAIL rand_out_div4 @%0d: got %h expected %h", i, out4, m_out[1]); end
         n_checks++; if (ps4 !== m_ps[1]) begin n_fail++; $display("FAIL rand_ps_div4 @%0d: got %b expected %b", i, ps4, m_ps[1]); end
         if ($urandom_range(7) == 0) en_out = 16'($urandom);
         if ($urandom_range(7) == 0) en_pwm = 16'($urandom);
         if ($urandom_range(3) == 0) begin
            case ($urandom_range(3))
               0: duty = 8'h00;
               1: duty = 8'hFF;
               default: duty = 8'($urandom);
            endcase
         end
         if (i == 2100) begin
            #2 rst_n = 1'b0;
            #2 rst_n = 1'b1;
         end
      end
   endtask

   initial begin
      test_reset;
      test_static_enables;
      test_duty_half;
      test_extremes;
      test_div4;
      test_reset_mid;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pwm_peripheral.md
PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

Interface
REQ-001 Parameter DIV, default 4, prescaler ratio (SCLK cycles per PWM tick), legal range 1..65535.
REQ-002 SCLK  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en_out_lo  input  8  output enable, bits 7:0 (register byte 0 from SPI write stage).
REQ-005 en_out_hi  input  8  output enable, bits 15:8 (register byte 1).
REQ-006 en_pwm_lo  input  8  PWM mode select, bits 7:0 (register byte 2).
REQ-007 en_pwm_hi  input  8  PWM mode select, bits 15:8 (register byte 3).
REQ-008 duty  input  8  PWM duty cycle code (register byte 4).
REQ-009 out  output  16  driven outputs.
REQ-010 period_start  output  1  one-cycle pulse marking start of each PWM period.

Function
REQ-011 16-bit prescaler shall count 0..DIV-1 and wrap to 0; tick asserted in the cycle prescaler equals DIV-1.
REQ-012 DIV=1 shall give a tick every SCLK cycle.
REQ-013 8-bit period counter shall advance only on tick, counting 0..254 then wrapping to 0; period = 255 ticks = 255*DIV SCLK cycles.
REQ-014 duty shadow register shall load from duty only on the tick where the counter wraps 254->0; mid-period duty changes shall not affect the current period.
REQ-015 PWM level shall be 1 when counter < shadow, else 0.
REQ-016 shadow = 0x00 -> PWM level constantly 0; shadow = 0xFF -> PWM level constantly 1 (no glitch at wrap).
REQ-017 Per bit i: en_out[i]=0 -> out[i]=0; en_out[i]=1 and en_pwm[i]=0 -> out[i]=1; en_out[i]=1 and en_pwm[i]=1 -> out[i]=PWM level.
REQ-018 en_out/en_pwm shall be applied immediately (no shadowing); out shall be registered, latency exactly 1 SCLK cycle from enable change or counter update.
REQ-019 period_start shall pulse high for exactly one SCLK cycle, registered, in the cycle after the counter becomes 0 (including first period after reset release, once the first wrap occurs).
REQ-020 Out-of-range counter values (255) shall not occur; the counter shall be forced to 0 if encountered.
REQ-021 All outputs shall be free of combinational paths from inputs.

Reset
REQ-022 rst_n low shall immediately clear prescaler, counter, duty shadow, out (0x0000) and period_start (0), independent of SCLK.
REQ-023 First rising SCLK after rst_n deassertion shall start prescaler at 0; shadow stays 0 until first wrap, so PWM bits read 0 for the first period.
REQ-024 Reset asserted mid-period shall abort the period; no partial pulse shall appear after release.

Verification
REQ-025 DIV=1, en_out=0xFFFF, en_pwm=0x0000 -> out=0xFFFF one cycle after enables set; en_out_lo=0x00 -> out=0xFF00 next cycle.
REQ-026 DIV=1, en_out=en_pwm=0x0001, duty=0x80 -> after first wrap, out[0] high 128 cycles, low 127 cycles, period 255 cycles; period_start spaced 255 cycles.
REQ-027 duty=0x00 and duty=0xFF each held across 3 periods -> out[0] constant 0 and constant 1 respectively, no single-cycle glitches at wrap.
REQ-028 DIV=4, duty=0x40 -> high time 256 SCLK cycles, period 1020 SCLK cycles; duty changed to 0xC0 mid-period -> change visible only from next period_start.
REQ-029 rst_n pulsed low mid-high-phase -> out=0x0000 and period_start=0 asynchronously; after release, no PWM high on out[0] until first counter wrap.
REQ-030 Random en_out/en_pwm/duty sequences checked cycle-by-cycle against a reference model of REQ-011..REQ-019.
